// File: rtl/uart_rx_line_if.sv
// Serial input and assembled-line result bus of uart_rx_line.
// MAX_LEN must match the MAX_LEN of the attached uart_rx_line.
interface uart_rx_line_if #(
    parameter int unsigned MAX_LEN = 11
);
    logic                 uart_rx;
    logic [8*MAX_LEN-1:0] data;
    logic [7:0]           len;
    logic                 valid;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output uart_rx, input data, len, valid, frame_err, parity_err);
    modport slave  (input uart_rx, output data, len, valid, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_line.sv
// UART receiver that assembles characters into a line, published on the
// terminator character or when MAX_LEN characters have been collected.
module uart_rx_line #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned MAX_LEN   = 11,
    parameter logic [7:0]  TERM      = 8'h0A
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_line_if.slave bus
);
    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF      = BIT_TICKS / 2;
    localparam int unsigned CNT_W     = $clog2(BIT_TICKS + 1);
    localparam int unsigned LINE_W    = 8 * MAX_LEN;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_sync;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              par_bad;
    logic [7:0]        idx;
    logic [LINE_W-1:0] line_buf;

    logic [LINE_W-1:0] line_c;
    logic [7:0]        len_c;
    logic              bit_done_c;
    logic              par_bad_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Line buffer with the just-received character placed at the current index.
    always_comb begin
        line_c = line_buf;
        for (int k = 0; k < int'(MAX_LEN); k++) begin
            if (idx == 8'(k)) begin
                line_c[8*k +: 8] = shreg;
            end
        end
        len_c      = idx + 8'd1;
        bit_done_c = (cnt == CNT_W'(BIT_TICKS - 1));
        // shreg bits above DATA_BITS stay zero, so ^shreg is the data parity.
        par_bad_c  = ((^shreg) ^ rx_sync) != (PARITY == 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            par_bad        <= 1'b0;
            idx            <= '0;
            line_buf       <= '0;
            bus.data       <= '0;
            bus.len        <= '0;
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            bus.valid      <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            state   <= DATA;
                            bit_idx <= '0;
                            shreg   <= '0;
                            par_bad <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done_c) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_sync;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (bit_done_c) begin
                        cnt     <= '0;
                        par_bad <= par_bad_c;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done_c) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_sync) begin
                            bus.frame_err <= 1'b1;
                            idx           <= '0;
                            line_buf      <= '0;
                        end else if (par_bad) begin
                            bus.parity_err <= 1'b1;
                            idx            <= '0;
                            line_buf       <= '0;
                        end else if (shreg == TERM || len_c == 8'(MAX_LEN)) begin
                            bus.data  <= line_c;
                            bus.len   <= len_c;
                            bus.valid <= 1'b1;
                            idx       <= '0;
                            line_buf  <= '0;
                        end else begin
                            line_buf <= line_c;
                            idx      <= len_c;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
